tow_player_input: RTL

//  Tug-of-war player front end: converts raw active-low push keys into clean single-cycle

---
 rtl/tow_player_input.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tow_player_input.sv
// Tug-of-war player front end.
// Turns the two raw active-low push keys into clean single-cycle move pulses.
// Each key passes through a 2-FF synchronizer, a debouncer and a press-to-pulse FSM.
// When cpu_en is set, LFSR-driven computer presses replace the right key.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous, active-high reset
//   key_l_n     raw left key, asynchronous, active-low
//   key_r_n     raw right key, asynchronous, active-low
//   cpu_en      1 = right player is the computer (key_r_n pulse discarded)
//   difficulty  computer press probability = difficulty / 2**DW per tick
//   L, R        registered one-cycle left / right move pulses
module tow_player_input #(
    parameter int unsigned DB_CYCLES   = 50000,
    parameter int unsigned TICK_CYCLES = 25000,
    parameter int unsigned DW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          key_l_n,
    input  logic          key_r_n,
    input  logic          cpu_en,
    input  logic [DW-1:0] difficulty,
    output logic          L,
    output logic          R
);

    localparam int unsigned CW = $clog2(DB_CYCLES);
    localparam int unsigned TW = $clog2(TICK_CYCLES);
    localparam int unsigned LW = 10;
    localparam int unsigned CH_L = 0;
    localparam int unsigned CH_R = 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [LW-1:0] LFSR_SEED = 10'h001;

    localparam logic [0:0] RELEASED = 1'b0;
    localparam logic [0:0] PRESSED  = 1'b1;

    // Channel index 0 = left, 1 = right; key level 1 = released.
    logic [1:0]    key_n;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    db;
    logic [CW-1:0] cnt [2];
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [1:0]    pulse_c;

    logic [TW-1:0] tick_cnt;
    logic [LW-1:0] lfsr;
    logic [LW-1:0] lfsr_next_c;
    logic          tick_c;
    logic          cpu_fire_c;

    assign key_n = {key_r_n, key_l_n};

    // Synchronizer and debounce: db follows s2 only after DB_CYCLES consecutive mismatching cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '1;
            s2 <= '1;
            db <= '1;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= key_n;
            s2 <= s1;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] != db[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        db[i]  <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Press-to-pulse FSM next state; a pulse is requested only on RELEASED -> PRESSED.
    always_comb begin
        state_next = state;
        pulse_c    = '0;
        for (int i = 0; i < 2; i++) begin
            case (state[i])
                RELEASED: begin
                    if (!db[i]) begin
                        state_next[i] = PRESSED;
                        pulse_c[i]    = 1'b1;
                    end
                end
                default: begin
                    if (db[i]) begin
                        state_next[i] = RELEASED;
                    end
                end
            endcase
        end
    end

    // Computer player: decision uses the LFSR value produced by this tick's advance.
    assign tick_c      = (tick_cnt == TICK_LAST);
    assign lfsr_next_c = {lfsr[LW-2:0], lfsr[9] ^ lfsr[6]};
    assign cpu_fire_c  = tick_c && (lfsr_next_c[DW-1:0] < difficulty);

    // Tick counter and LFSR run regardless of cpu_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt <= '0;
            lfsr     <= LFSR_SEED;
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TW'(1);
            if (tick_c) begin
                lfsr <= lfsr_next_c;
            end
        end
    end

    // FSM state and output registers; the right channel keeps running but is muxed out under cpu_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= {RELEASED, RELEASED};
            L     <= 1'b0;
            R     <= 1'b0;
        end else begin
            state <= state_next;
            L     <= pulse_c[CH_L];
            R     <= cpu_en ? cpu_fire_c : pulse_c[CH_R];
        end
    end

endmodule
